// File: rtl/usb_ep_buf_rd_arb.sv
// Read-port arbiter for usb_ep_buf: the TX engine has priority, and a wait counter
// bounds how long the bus-side read path can be denied.
module usb_ep_buf_rd_arb #(
    parameter int RWIDTH   = 16,
    parameter int ARW      = 11 - $clog2(RWIDTH/8),
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ARW-1:0]    buf_rd_addr_0,
    output logic              buf_rd_en_0,
    input  logic [RWIDTH-1:0] buf_rd_data_1,
    input  logic              tx_req,
    input  logic [ARW-1:0]    tx_addr,
    output logic              tx_ack,
    output logic [RWIDTH-1:0] tx_data,
    output logic              tx_valid,
    input  logic              bus_req,
    input  logic [ARW-1:0]    bus_addr,
    output logic              bus_ack,
    output logic [RWIDTH-1:0] bus_data,
    output logic              bus_valid
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]        r_wait;
    logic [3:0]        w_wait_nxt;
    logic              w_force;
    logic              w_tx_ack;
    logic              w_bus_ack;
    logic              r_tx_valid;
    logic              r_bus_inflight;
    logic              r_bus_valid;
    logic [RWIDTH-1:0] r_bus_data;

    // Bus overrides TX only once it has been denied MAX_WAIT cycles in a row.
    assign w_force = (r_wait == LP_MAX_WAIT);

    always_comb begin
        w_tx_ack  = 1'b0;
        w_bus_ack = 1'b0;
        if (!rst) begin
            if (bus_req && (!tx_req || w_force)) begin
                w_bus_ack = 1'b1;
            end else if (tx_req) begin
                w_tx_ack = 1'b1;
            end
        end
    end

    always_comb begin
        w_wait_nxt = 4'd0;
        if (bus_req && !w_bus_ack) begin
            w_wait_nxt = w_force ? r_wait : r_wait + 4'd1;
        end
    end

    assign tx_ack        = w_tx_ack;
    assign bus_ack       = w_bus_ack;
    assign buf_rd_en_0   = w_tx_ack | w_bus_ack;
    assign buf_rd_addr_0 = w_bus_ack ? bus_addr : tx_addr;

    // Cycle N grant -> cycle N+1 owner flags; bus data lands one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait         <= 4'd0;
            r_tx_valid     <= 1'b0;
            r_bus_inflight <= 1'b0;
            r_bus_valid    <= 1'b0;
            r_bus_data     <= '0;
        end else begin
            r_wait         <= w_wait_nxt;
            r_tx_valid     <= w_tx_ack;
            r_bus_inflight <= w_bus_ack;
            r_bus_valid    <= r_bus_inflight;
            if (r_bus_inflight) begin
                r_bus_data <= buf_rd_data_1;
            end
        end
    end

    // A TX read acked just before reset must not pulse while reset is asserted.
    assign tx_valid  = r_tx_valid & ~rst;
    assign tx_data   = buf_rd_data_1;
    assign bus_valid = r_bus_valid;
    assign bus_data  = r_bus_data;

endmodule

// File: doc/usb_ep_buf_rd_arb.md
Name: usb_ep_buf_rd_arb

Overview:
Arbiter that shares the single read port of usb_ep_buf between two requesters: the USB TX engine and the bus-side (CPU) read path. The TX engine has priority because it is time-critical. A wait counter guarantees that the bus requester is never starved. The block sits directly on rd_addr_0/rd_en_0/rd_data_1 of usb_ep_buf and routes the one-cycle-latency read data back to whichever requester owns it.

Parameters:
RWIDTH, 16, read port width in bits (8/16/32); must match the usb_ep_buf instance.
ARW, 11 - $clog2(RWIDTH/8), read address width (derived; do not override).
MAX_WAIT, 3, consecutive denied bus cycles before the bus is forced to win; legal range 1..15.

Ports:
clk  in  1  single clock, shared with usb_ep_buf rd_clk.
rst  in  1  synchronous reset, active-high.
buf_rd_addr_0  out  ARW  address to usb_ep_buf rd_addr_0.
buf_rd_en_0  out  1  read enable to usb_ep_buf rd_en_0.
buf_rd_data_1  in  RWIDTH  data from usb_ep_buf rd_data_1 (one cycle after enable).
tx_req  in  1  TX engine read request, held with tx_addr.
tx_addr  in  ARW  TX read address.
tx_ack  out  1  TX request accepted this cycle (combinational).
tx_data  out  RWIDTH  TX read data; meaningful only while tx_valid=1.
tx_valid  out  1  one-cycle pulse: tx_data holds the result of the request acked last cycle.
bus_req  in  1  bus read request, held with bus_addr until bus_ack.
bus_addr  in  ARW  bus read address.
bus_ack  out  1  bus request accepted this cycle (combinational).
bus_data  out  RWIDTH  registered bus read data, held until the next bus_valid.
bus_valid  out  1  one-cycle pulse: bus_data updated this cycle.

Behaviour:
- Reset (rst=1 at a clk edge): tx_valid=0, bus_valid=0, bus_data=0, wait counter=0, in-flight owner cleared.
- Outputs during reset: tx_ack=0, bus_ack=0, buf_rd_en_0=0. Requests during reset are ignored.
- Arbitration is combinational in cycle 0:
  - tx_req only: TX wins.
  - bus_req only: bus wins.
  - Both asserted: TX wins unless the force flag is set (wait counter == MAX_WAIT), in which case the bus wins.
- Winner outputs: buf_rd_en_0 = tx_ack | bus_ack; buf_rd_addr_0 = winner's address. When idle, buf_rd_addr_0 = tx_addr; the value is a don't-care.
- At most one ack per cycle, so tx_ack & bus_ack is never 1.
- Latency: a grant in cycle N gives owner_valid=1 in cycle N+1.
  - tx_data = buf_rd_data_1 passed straight through; tx_valid is registered.
  - bus_data is captured from buf_rd_data_1 on the N+1 edge. It is visible, with bus_valid=1, in cycle N+2 and held thereafter.
- Back-to-back grants are allowed every cycle with no bubble. The owner register tracks one in-flight read per cycle.
- Wait counter (4 bits):
  - Increments when bus_req=1 and bus_ack=0, saturating at MAX_WAIT.
  - Clears when bus_ack=1 or bus_req=0.
  - Force flag = (counter == MAX_WAIT).
- Worst-case bus wait under continuous TX traffic: bus acked on its (MAX_WAIT+1)th requesting cycle. TX is then delayed by exactly one cycle; tx_ack=0 that cycle and TX keeps requesting.
- Requesters must hold req and addr stable until ack. Dropping req before ack is legal; no read is issued.
- Reset mid-operation: an in-flight read acked in the cycle before reset produces no valid pulse. bus_data returns to 0.

Test Plan:
- Reset: hold rst 3 cycles with tx_req=bus_req=1 -> tx_ack=bus_ack=buf_rd_en_0=0, tx_valid=bus_valid=0, bus_data=0.
- TX-only single read: preload word 3 = 16'hcafe, tx_req=1 with tx_addr=3 for one cycle -> tx_ack=1 and buf_rd_addr_0=3 that cycle; next cycle tx_valid=1, tx_data=16'hcafe.
- Bus-only single read: preload word 5 = 16'h127b, bus_req with bus_addr=5 -> bus_ack same cycle; bus_valid=1 and bus_data=16'h127b two cycles later; bus_data still 16'h127b 10 cycles later.
- Contention, MAX_WAIT=3: tx_req held continuously with addresses 0,1,2,...; bus_req=1 with bus_addr=7 -> tx acked on cycles 0,1,2; bus acked on cycle 3 (tx_ack=0 there); TX resumes on cycle 4; counter back to 0.
- Back-to-back alternation: TX request on even cycles, bus request on odd cycles for 20 cycles -> buf_rd_en_0=1 every cycle; every data word routed to the correct requester; no valid lost or duplicated.
- Reset mid-flight: bus acked at cycle N, rst=1 at cycle N+1 -> bus_valid stays 0 and bus_data=0 after reset.
